// File: rtl/clock_divider.sv
// Gated programmable-rate serial clock: a burst of NUM_PERIODS periods per start.
// Optional macro CLOCK_DIVIDER_DONE_PULSE_EN adds a one-cycle o_done pulse.
module clock_divider #(
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned NUM_PERIODS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [8:0] i_config,
  input  logic       i_start_n,
  output logic       o_idle,
  output logic       o_clk
`ifdef CLOCK_DIVIDER_DONE_PULSE_EN
  ,
  output logic       o_done
`endif
);

  localparam int unsigned PW = $clog2(NUM_PERIODS) + 1;
  localparam logic [PW-1:0] PER_LAST = PW'(NUM_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN
  } state_t;

  state_t        state_q, state_n;
  logic [7:0]    div_q, div_n;
  logic [7:0]    ph_q, ph_n;
  logic [PW-1:0] per_q, per_n;
  logic          clk_q, clk_n;
  logic          idle_q, idle_n;
  logic          done_n;

  logic [7:0] eff_div;
  logic [7:0] low_len;
  logic [7:0] ph_inc;
  logic       ph_last;
  logic       per_last;

  assign eff_div  = (div_q < 8'd2) ? 8'd2 : div_q;
  assign low_len  = eff_div - {1'b0, eff_div[7:1]};
  assign ph_inc   = ph_q + 8'd1;
  assign ph_last  = (ph_q == (eff_div - 8'd1));
  assign per_last = (per_q == PER_LAST);

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      div_q   <= 8'(DEFAULT_DIV);
      ph_q    <= '0;
      per_q   <= '0;
      clk_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      ph_q    <= ph_n;
      per_q   <= per_n;
      clk_q   <= clk_n;
      idle_q  <= idle_n;
    end
  end

  // Next-state: config/start in IDLE, phase and period counting in RUN
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    ph_n    = ph_q;
    per_n   = per_q;
    clk_n   = 1'b0;
    idle_n  = idle_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_n = 1'b1;
        ph_n   = '0;
        per_n  = '0;
        if (i_config[0]) begin
          div_n = i_config[8:1];
        end else if (!i_start_n) begin
          state_n = SETUP;
          idle_n  = 1'b0;
        end
      end
      SETUP: begin
        state_n = RUN;
        idle_n  = 1'b0;
        ph_n    = '0;
        per_n   = '0;
        clk_n   = 1'b0;
      end
      RUN: begin
        idle_n = 1'b0;
        if (ph_last) begin
          ph_n = '0;
          if (per_last) begin
            state_n = IDLE;
            idle_n  = 1'b1;
            per_n   = '0;
            done_n  = 1'b1;
          end else begin
            per_n = per_q + 1'b1;
          end
        end else begin
          ph_n  = ph_inc;
          clk_n = (ph_inc >= low_len);
        end
      end
      default: begin
        state_n = IDLE;
        idle_n  = 1'b1;
      end
    endcase
  end

  assign o_idle = idle_q;
  assign o_clk  = clk_q;

`ifdef CLOCK_DIVIDER_DONE_PULSE_EN
  logic done_q;

  // Completion pulse; cleared by reset so an aborted burst never reports
  always_ff @(posedge i_clk) begin
    if (i_rst) done_q <= 1'b0;
    else       done_q <= done_n;
  end

  assign o_done = done_q;
`else
  logic unused_done;
  assign unused_done = done_n;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Randomized and directed bench for clock_divider.
// Reference model expands each burst into an expected waveform queue.
module tb_clock_divider;

  logic       clk;
  logic       rst;
  logic [8:0] cfg;
  logic       start_n;
  logic       idle;
  logic       sclk;
  logic       done;

  int n_chk;
  int n_fail;

  logic [2:0] exp_q[$];
  int         mdiv;

  clock_divider #(
    .DEFAULT_DIV(2),
    .NUM_PERIODS(8)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_config (cfg),
    .i_start_n(start_n),
    .o_idle   (idle),
    .o_clk    (sclk)
`ifdef CLOCK_DIVIDER_DONE_PULSE_EN
    ,
    .o_done   (done)
`endif
  );

`ifndef CLOCK_DIVIDER_DONE_PULSE_EN
  assign done = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Expected {done, idle, clk} for every cycle of one burst
  task automatic plan_burst();
    int d, lo, hi;
    d  = eff(mdiv);
    hi = d / 2;
    lo = d - hi;
    exp_q.push_back(3'b000);
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < lo; i++) exp_q.push_back(3'b000);
      for (int i = 0; i < hi; i++) exp_q.push_back(3'b001);
    end
    exp_q.push_back(3'b110);
  endtask

  task automatic cyc(input logic [8:0] c, input logic sn, input logic r);
    logic [2:0] e;
    cfg     = c;
    start_n = sn;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      mdiv = 2;
      e = 3'b010;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = 3'b010;
      if (c[0]) begin
        mdiv = int'(c[8:1]);
      end else if (!sn) begin
        plan_burst();
        e = exp_q.pop_front();
      end
    end
    chk("idle", int'(idle), int'(e[1]));
    chk("sclk", int'(sclk), int'(e[0]));
`ifdef CLOCK_DIVIDER_DONE_PULSE_EN
    chk("done", int'(done), int'(e[2]));
`endif
  endtask

  task automatic set_div(input int d);
    logic [7:0] dv;
    dv = 8'(d);
    cyc({dv, 1'b1}, 1'b1, 1'b0);
  endtask

  task automatic burst(input int d);
    int n, r;
    logic pc;
    n  = 0;
    r  = 0;
    pc = 1'b0;
    cyc(9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 3000 && idle == 1'b0; i++) begin
      n++;
      if (sclk && !pc) r++;
      pc = sclk;
      cyc(9'h000, 1'b1, 1'b0);
    end
    chk("burst_len", n, 8 * eff(d) + 1);
    chk("burst_rises", r, 8);
    chk("burst_end", int'(idle), 1);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    mdiv    = 2;
    cfg     = '0;
    start_n = 1'b1;
    rst     = 1'b1;

    for (int i = 0; i < 16; i++) cyc(9'h000, 1'b1, 1'b1);
    cyc(9'h000, 1'b1, 1'b0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_sclk", int'(sclk), 0);

    burst(2);

    cyc(9'h1F5, 1'b1, 1'b0);
    burst(250);

    set_div(100);
    burst(100);
    set_div(4);
    burst(4);

    set_div(2);
    burst(2);

    set_div(4);
    cyc(9'h000, 1'b0, 1'b0);
    cyc({8'd10, 1'b1}, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(9'h000, 1'b1, 1'b0);
    chk("busy_ignored", int'(idle), 1);
    burst(4);

    cyc({8'd6, 1'b1}, 1'b0, 1'b0);
    cyc(9'h000, 1'b1, 1'b0);
    chk("cfg_wins", int'(idle), 1);
    burst(6);

    for (int i = 0; i < 60; i++) cyc(9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) cyc(9'h000, 1'b1, 1'b0);

    set_div(100);
    cyc(9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) cyc(9'h000, 1'b1, 1'b0);
    cyc(9'h000, 1'b1, 1'b1);
    chk("abort_idle", int'(idle), 1);
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_done", int'(done), 0);
    cyc(9'h000, 1'b1, 1'b0);
    burst(2);

    for (int i = 0; i < 4000; i++) begin
      logic [8:0] c;
      logic       sn, r;
      c  = 9'h000;
      if ($urandom_range(7) == 0)
        c = {8'($urandom_range(12)), 1'b1};
      sn = ($urandom_range(3) != 0);
      r  = ($urandom_range(499) == 0);
      cyc(c, sn, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
